// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: field widths, special encodings, flag indices
// and the result/state types used by the rounding output stage.
package dlfloat_pkg;

   localparam int EXP_W      = 6;
   localparam int MANT_W     = 9;
   localparam int EXT_W      = 4;
   localparam int MAG_W      = EXP_W + MANT_W;
   localparam int DATA_W     = 1 + MAG_W;
   localparam int EXT_DATA_W = DATA_W + EXT_W;
   localparam int FLAG_W     = 5;

   localparam logic [DATA_W-1:0] POS_INF  = 16'h7FFF;
   localparam logic [DATA_W-1:0] NEG_INF  = 16'hFFFF;
   localparam logic [DATA_W-1:0] NEG_ZERO = 16'h8000;
   localparam logic [MAG_W-1:0]  MAG_MAX  = 15'h7FFF;

   localparam int FLG_INVALID   = 4;
   localparam int FLG_INEXACT   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_DIVZ      = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [FLAG_W-1:0] flags;
   } result_t;

endpackage

// File: rtl/dlfloat_rne_round.sv
// Combinational round-to-nearest-even from the 20-bit extended DLFloat16 result
// to 16 bits, merging inexact/overflow into the exception vector.
module dlfloat_rne_round
   import dlfloat_pkg::*;
(
   input  logic [EXT_DATA_W-1:0] in_data,
   input  logic [FLAG_W-1:0]     in_flags,
   output logic [DATA_W-1:0]     out_data,
   output logic [FLAG_W-1:0]     out_flags
);

   function automatic logic rne_up(input logic lsb, input logic guard, input logic [2:0] rest);
      return guard & ((|rest) | lsb);
   endfunction

   logic [MAG_W-1:0] mag;
   logic [EXT_W-1:0] ext;
   logic [MAG_W-1:0] rounded;
   logic             special;
   logic             zero;
   logic             up;

   assign mag     = in_data[EXT_DATA_W-2:EXT_W];
   assign ext     = in_data[EXT_W-1:0];
   assign special = (mag == MAG_MAX);
   assign zero    = (in_data[EXT_DATA_W-2:0] == '0);
   assign up      = rne_up(in_data[EXT_W], ext[3], ext[2:0]);
   // Cannot wrap: the only magnitude that would carry out is the special one.
   assign rounded = mag + {{(MAG_W-1){1'b0}}, up};

   always_comb begin
      out_data  = in_data[EXT_DATA_W-1:EXT_W];
      out_flags = in_flags;
      if (!special && !zero) begin
         out_data               = {in_data[EXT_DATA_W-1], rounded};
         out_flags[FLG_INEXACT] = in_flags[FLG_INEXACT] | (|ext);
         if (rounded == MAG_MAX)
            out_flags[FLG_OVERFLOW] = 1'b1;
      end
   end

endmodule

// File: rtl/dlfloat_round_stage.sv
// DLFloat16 output stage: RNE rounding, two-entry skid pipeline with a
// registered in_ready, and a software-clearable sticky copy of delivered flags.
module dlfloat_round_stage
   import dlfloat_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [EXT_DATA_W-1:0] in_data,
   input  logic [FLAG_W-1:0]     in_flags,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [FLAG_W-1:0]     out_flags,
   output logic [FLAG_W-1:0]     sticky_flags,
   input  logic                  flag_clr
);

   skid_state_t state;
   skid_state_t state_next;
   result_t     res_p0;
   result_t     out_p1;
   result_t     skid_p1;
   logic        accept;
   logic        drain;

   // Stage 0: combinational rounding on the input side
   dlfloat_rne_round u_round (
      .in_data   (in_data),
      .in_flags  (in_flags),
      .out_data  (res_p0.data),
      .out_flags (res_p0.flags)
   );

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b0;
      end else begin
         state    <= state_next;
         in_ready <= (state_next != ST_TWO);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: if (accept) state_next = ST_ONE;
         ST_ONE: begin
            if (accept && !drain)      state_next = ST_TWO;
            else if (!accept && drain) state_next = ST_EMPTY;
         end
         ST_TWO:   if (drain) state_next = ST_ONE;
         default:  state_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state != ST_EMPTY);
      out_data  = out_p1.data;
      out_flags = out_p1.flags;
   end

   // Stage 1: output and skid registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out_p1 <= '0;
      else if ((state == ST_EMPTY && accept) || (state == ST_ONE && accept && drain))
         out_p1 <= res_p0;
      else if (state == ST_TWO && drain)
         out_p1 <= skid_p1;
   end

   always_ff @(posedge clk) begin
      if (state == ST_ONE && accept && !drain)
         skid_p1 <= res_p0;
   end

   // A clear coinciding with a handshake keeps only the flags delivered now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sticky_flags <= '0;
      else if (flag_clr)
         sticky_flags <= drain ? out_flags : '0;
      else if (drain)
         sticky_flags <= sticky_flags | out_flags;
   end

endmodule

// File: tb/tb_dlfloat_round_stage.sv
// Directed bench for dlfloat_round_stage: rounding vectors, backpressure,
// sticky flag behaviour and asynchronous reset.
module tb_dlfloat_round_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_data;
   logic [4:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [4:0]  out_flags;
   logic [4:0]  sticky_flags;
   logic        flag_clr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dlfloat_round_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_flags     (in_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .flag_clr     (flag_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one value with out_ready high, check the registered result.
   task automatic send_chk(input string tag, input logic [19:0] d, input logic [4:0] f,
                           input logic [15:0] exp_d, input logic [4:0] exp_f);
      in_valid = 1'b1;
      in_data  = d;
      in_flags = f;
      step();
      in_valid = 1'b0;
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
      chk({tag, "_flags"}, 32'(out_flags), 32'(exp_f));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_flags  = '0;
      out_ready = 1'b0;
      flag_clr  = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h0000);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      chk("rst_sticky", 32'(sticky_flags), 32'd0);
      #11;
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Rounding vectors, each drained on the following edge
      out_ready = 1'b1;
      send_chk("tie_even_down", 20'h3E008, 5'b00000, 16'h3E00, 5'b01000);
      send_chk("tie_even_up", 20'h3E018, 5'b00000, 16'h3E02, 5'b01000);
      send_chk("exact", 20'h3E010, 5'b00000, 16'h3E01, 5'b00000);
      send_chk("mant_carry", 20'h3FFF8, 5'b00000, 16'h4000, 5'b01000);
      send_chk("round_ovf", 20'h7FFEC, 5'b00000, 16'h7FFF, 5'b01100);
      send_chk("neg_inf_pass", 20'hFFFF0, 5'b10000, 16'hFFFF, 5'b10000);
      send_chk("neg_zero", 20'h80000, 5'b00010, 16'h8000, 5'b00010);
      send_chk("exp63_finite", 20'h7FE08, 5'b00000, 16'h7FE0, 5'b01000);
      step();
      chk("drained_empty", 32'(out_valid), 32'd0);

      // Sticky accumulation after a plain clear
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("sticky_cleared", 32'(sticky_flags), 32'd0);
      send_chk("stk_ovf", 20'h3E010, 5'b00100, 16'h3E01, 5'b00100);
      send_chk("stk_divz", 20'h3E020, 5'b00001, 16'h3E02, 5'b00001);
      step();
      chk("sticky_or", 32'(sticky_flags), 32'b00101);
      send_chk("stk_inexact", 20'h3E008, 5'b00000, 16'h3E00, 5'b01000);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("sticky_clr_hs", 32'(sticky_flags), 32'b01000);

      // Backpressure: out_ready low for three edges
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_flags  = 5'b00000;
      in_data   = 20'h11110;
      step();
      chk("bp_ready_1", 32'(in_ready), 32'd1);
      chk("bp_out_a", 32'(out_data), 32'h1111);
      in_data = 20'h22220;
      step();
      chk("bp_ready_2", 32'(in_ready), 32'd0);
      chk("bp_hold_a1", 32'(out_data), 32'h1111);
      in_data = 20'h33330;
      step();
      chk("bp_ready_3", 32'(in_ready), 32'd0);
      chk("bp_hold_a2", 32'(out_data), 32'h1111);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_out_b", 32'(out_data), 32'h2222);
      chk("bp_ready_4", 32'(in_ready), 32'd1);
      step();
      chk("bp_out_c", 32'(out_data), 32'h3333);
      in_data = 20'h44440;
      step();
      in_valid = 1'b0;
      chk("bp_out_d", 32'(out_data), 32'h4444);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Fill both entries, then reset asynchronously mid-cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 20'h3E018;
      step();
      in_data = 20'h3E028;
      step();
      in_valid = 1'b0;
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      chk("pre_rst_sticky", 32'(sticky_flags), 32'b01000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_vld", 32'(out_valid), 32'd0);
      chk("async_rst_data", 32'(out_data), 32'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_sticky", 32'(sticky_flags), 32'd0);
      chk("post_rst_vld", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dlfloat_round_stage.md
# dlfloat_round_stage

Output stage for the DLFloat16 arithmetic units. Consumes the 20-bit extended result (1 sign, 6 exponent, 13 mantissa: 9 kept plus 4 guard/round/sticky) and the 5-bit exception vector produced by the registered divider, multiplier and adder. It rounds to 16-bit DLFloat16 using round-to-nearest-even, merges the rounding exceptions into the vector, and returns results through a valid/ready pipeline with a skid buffer. It also keeps a sticky, software-clearable copy of all flags delivered.

## Interface
- No parameters; all widths are fixed by the DLFloat16 format.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream result is valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  20  {sign, exp[5:0], mant[12:0]}.
- in_flags  in  5  {invalid, inexact, overflow, underflow, div_by_zero}.
- out_valid  out  1  rounded result is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  16  {sign, exp[5:0], mant[8:0]}.
- out_flags  out  5  flags for out_data, in the same bit order.
- sticky_flags  out  5  OR of all out_flags delivered since reset or clear.
- flag_clr  in  1  synchronous clear of sticky_flags.

## Operation
- Special pass-through: if in_data[18:4] == 15'h7FFF (inf/NaN), then out_data = in_data[19:4] and out_flags = in_flags. No rounding is applied.
- Zero: if in_data[18:0] == 0, then out_data = {sign, 15'b0} and out_flags = in_flags.
- Rounding for all other inputs:
  - lsb = in_data[4], G = in_data[3], S = |in_data[2:0].
  - round_up = G & (S | lsb).
  - {exp, mant9} = in_data[18:4] + round_up, a 15-bit add. A mantissa carry propagates into the exponent. The sign is never altered.
- Flag merge:
  - inexact |= |in_data[3:0].
  - If the rounded {exp, mant9} == 15'h7FFF and the input was not special, set overflow. The result is inf (sign kept).
  - All other in_flags bits pass unchanged.
- Exponent 63 with mantissa < 9'h1FF is an ordinary finite value.
- Sticky flags:
  - On each output handshake (out_valid & out_ready), sticky_flags |= out_flags.
  - flag_clr zeroes sticky_flags.
  - If flag_clr and a handshake occur in the same cycle, sticky_flags = that cycle's out_flags. Clear drops only the older history.

## Timing
- Rounding is combinational on the input side. The result is captured at the accepting edge.
- Latency is 1 cycle: an accept at edge N gives out_valid high after edge N.
- Throughput is one result per cycle while out_ready = 1.
- Output register (OUT) plus a one-entry skid register (SKID). State machine:
  - EMPTY → ONE: on accept.
  - ONE → ONE: accept together with drain.
  - ONE → TWO: accept with no drain; the result goes to SKID.
  - TWO → ONE: on drain; SKID moves to OUT.
  - ONE → EMPTY: drain with no accept.
- in_ready = (state != TWO), registered. No combinational path exists from out_ready to in_ready.
- out_data and out_flags are held stable while out_valid & !out_ready.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- Reset values: out_valid = 0, out_data = 16'h0000, out_flags = 5'b0, sticky_flags = 5'b0, in_ready = 1 from the first edge after release, state = EMPTY.
- Reset asserted mid-operation discards OUT and SKID immediately, without waiting for a clock edge.
- in_valid is ignored while in_ready = 0. Upstream holds its data in that case.

## Structure
- Shared package dlfloat_pkg holds:
  - Field widths: EXP_W = 6, MANT_W = 9, EXT_W = 4.
  - Special encodings: POS_INF = 16'h7FFF, NEG_INF = 16'hFFFF, NEG_ZERO = 16'h8000.
  - Flag bit indices: FLG_INVALID = 4 down to FLG_DIVZ = 0.
- One combinational sub-module, dlfloat_rne_round. It maps {in_data, in_flags} to {out_data, out_flags} and can be reused by other units.
- The top level holds the skid/valid-ready control and the sticky register.

## Test plan
- Tie to even: in_data = 20'h3E008 → out_data = 16'h3E00, inexact = 1. Also in_data = 20'h3E018 → out_data = 16'h3E02, inexact = 1.
- Exact value: in_data = 20'h3E010 → out_data = 16'h3E01, out_flags = 0.
- Overflow by rounding: in_data = 20'h7FFEC → out_data = 16'h7FFF with overflow and inexact set. Also in_data = 20'hFFFF0 with invalid set → out_data = 16'hFFFF, flags passed through unchanged.
- Backpressure: stream 4 values with out_ready held low for 3 cycles.
  - in_ready drops after the 2nd accept.
  - All 4 values emerge in order.
  - out_data is stable while stalled.
- Sticky flags:
  - Deliver overflow, then div_by_zero → sticky_flags = 5'b00101.
  - flag_clr in the same cycle as an inexact handshake → 5'b01000.
- Async reset:
  - Assert rst_n low while in state TWO → out_valid drops to 0 before the next edge.
  - After release → in_ready = 1 and sticky_flags = 0.
